// File: rtl/df_forward_unit_if.sv
// Decode-to-DSP48 opmode bundle for the forwarding unit.
// Master drives the instruction fields, slave returns the corrected opmode.
interface df_forward_unit_if #(
    parameter int ADDR_W = 5,
    parameter int OPM_W  = 7
);
    logic              ENABLE;
    logic [ADDR_W-1:0] D;
    logic [ADDR_W-1:0] C;
    logic [OPM_W-1:0]  OPMODE;
    logic [OPM_W-1:0]  OPMODE_DF;

    modport master (
        output ENABLE,
        output D,
        output C,
        output OPMODE,
        input  OPMODE_DF
    );

    modport slave (
        input  ENABLE,
        input  D,
        input  C,
        input  OPMODE,
        output OPMODE_DF
    );
endinterface

// File: rtl/df_forward_unit.sv
// One-deep RAW forwarding for the DSP48 C operand.
// Rewrites the Z-mux field from C to P when C matches the prior destination.
module df_forward_unit #(
    parameter int          ADDR_W = 5,
    parameter int          OPM_W  = 7,
    parameter logic [2:0]  Z_C    = 3'b011,
    parameter logic [2:0]  Z_P    = 3'b010
) (
    input  logic               CLK,
    input  logic               RESET,
    df_forward_unit_if.slave   bus
);
    logic [ADDR_W-1:0] r_d_prev;
    logic              r_v_prev;
    logic [OPM_W-1:0]  r_opmode_df;

    logic              w_hit;
    logic              w_writes;
    logic [OPM_W-1:0]  w_opmode_cor;

    // Hazard detect and Z-field rewrite; X and Y pass through untouched
    always_comb begin
        w_hit        = r_v_prev
                     && (bus.C == r_d_prev)
                     && (bus.OPMODE[OPM_W-1:4] == Z_C);
        w_writes     = |bus.OPMODE;
        w_opmode_cor = bus.OPMODE;
        if (w_hit) begin
            w_opmode_cor = {Z_P, bus.OPMODE[3:0]};
        end
    end

    // History and output register; a stall leaves the hazard window open
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_d_prev    <= '0;
            r_v_prev    <= 1'b0;
            r_opmode_df <= '0;
        end else if (bus.ENABLE) begin
            r_d_prev    <= bus.D;
            r_v_prev    <= w_writes;
            r_opmode_df <= w_opmode_cor;
        end
    end

    assign bus.OPMODE_DF = r_opmode_df;
endmodule

// File: tb/tb_df_forward_unit.sv
// Scoreboard bench for df_forward_unit.
// Expected opmodes are queued at drive time and popped after each edge.
module tb_df_forward_unit;
    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDP = 7'b0100011;
    localparam logic [6:0] ZNC  = 7'b0000011;

    logic CLK;
    logic RESET;

    df_forward_unit_if #(.ADDR_W(5), .OPM_W(7)) bus ();

    df_forward_unit #(
        .ADDR_W (5),
        .OPM_W  (7),
        .Z_C    (3'b011),
        .Z_P    (3'b010)
    ) u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [6:0] sb_q[$];

    logic [4:0] m_dprev;
    logic       m_vprev;
    logic [6:0] m_out;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Safety net so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string tag,
                         input logic [6:0] got,
                         input logic [6:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_dprev = '0;
        m_vprev = 1'b0;
        m_out   = '0;
    endtask

    // Drive one cycle, predict, wait an edge, compare
    task automatic issue(input string tag,
                         input logic en,
                         input logic [6:0] opm,
                         input logic [4:0] d,
                         input logic [4:0] c);
        logic [6:0] exp;
        logic [6:0] got;
        bus.ENABLE = en;
        bus.OPMODE = opm;
        bus.D      = d;
        bus.C      = c;
        if (en) begin
            if (m_vprev && c == m_dprev && opm[6:4] == 3'b011)
                exp = {3'b010, opm[3:0]};
            else
                exp = opm;
            m_out   = exp;
            m_dprev = d;
            m_vprev = (opm != 7'd0);
        end else begin
            exp = m_out;
        end
        sb_q.push_back(exp);
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_empty"}, bus.OPMODE_DF, 7'bx);
        end else begin
            got = bus.OPMODE_DF;
            check(tag, got, sb_q.pop_front());
        end
    endtask

    initial begin
        logic [6:0] ro;
        RESET      = 1'b0;
        bus.ENABLE = 1'b0;
        bus.OPMODE = '0;
        bus.D      = '0;
        bus.C      = '0;
        model_reset();

        for (int i = 0; i < 4; i++) begin
            bus.ENABLE = 1'($urandom);
            bus.OPMODE = 7'($urandom);
            bus.D      = 5'($urandom);
            bus.C      = 5'($urandom);
            @(posedge CLK);
            #1;
            check("rst_hold", bus.OPMODE_DF, 7'd0);
        end
        RESET = 1'b1;

        issue("first",  1'b1, ADD, 5'd2, 5'd1);
        issue("chain1", 1'b1, ADD, 5'd3, 5'd2);
        issue("chain2", 1'b1, ADD, 5'd2, 5'd3);
        issue("chain3", 1'b1, ADD, 5'd1, 5'd1);

        issue("zpre",   1'b1, ADD, 5'd4, 5'd0);
        issue("z_not_c",1'b1, ZNC, 5'd0, 5'd4);

        issue("nop",    1'b1, 7'd0, 5'd5, 5'd0);
        issue("postnop",1'b1, ADD, 5'd0, 5'd5);

        issue("stpre",  1'b1, ADD, 5'd6, 5'd9);
        for (int i = 0; i < 3; i++)
            issue("stall", 1'b0, 7'($urandom), 5'($urandom),
                  5'($urandom));
        issue("stfwd",  1'b1, ADD, 5'd8, 5'd6);

        issue("arpre",  1'b1, ADD, 5'd7, 5'd1);
        #2;
        RESET = 1'b0;
        #1;
        check("async_rst", bus.OPMODE_DF, 7'd0);
        model_reset();
        #1;
        RESET = 1'b1;
        issue("post_rst", 1'b1, ADD, 5'd3, 5'd7);
        issue("selfdep",  1'b1, ADD, 5'd9, 5'd9);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: ro = ADD;
                1: ro = ZNC;
                2: ro = 7'd0;
                default: ro = 7'($urandom);
            endcase
            issue("rand", ($urandom_range(0, 3) != 0), ro,
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
